// File: rtl/writeback_unit.sv
// writeback_unit: in-order write-back buffer in front of the register file.
// Results are queued in a small FIFO and drained one per cycle into a
// registered write stage. Pending values are forwarded to the decode read
// ports so decode never sees stale register file data.
module writeback_unit #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     flush,
  output logic                     RegWrite,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          WriteData,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     fwd1_valid,
  output logic [XLEN-1:0]          fwd1_data,
  output logic                     fwd2_valid,
  output logic [XLEN-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            push;
  logic            pop;

  // Readiness depends on occupancy only, so a full FIFO stalls even when a pop is due.
  assign in_ready = (count != CW'(DEPTH));
  // Writes to x0 complete the handshake but are never stored; flush beats are dropped.
  assign push = in_valid && in_ready && (in_rd != 5'd0) && !flush;
  assign pop  = (count != '0) && !flush;

  // FIFO storage, pointers, occupancy and the registered write stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (flush) begin
      // The write stage already showing RegWrite completes at this edge;
      // everything still queued is dropped.
      head     <= tail;
      count    <= '0;
      RegWrite <= 1'b0;
    end else begin
      if (push) begin
        mem_rd[tail]   <= in_rd;
        mem_data[tail] <= in_data;
        tail           <= tail + AW'(1);
      end
      if (pop) begin
        RegWrite  <= 1'b1;
        rd        <= mem_rd[head];
        WriteData <= mem_data[head];
        head      <= head + AW'(1);
      end else begin
        RegWrite  <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Forwarding: scan oldest to youngest so the youngest matching entry wins;
  // the write stage is older than every queued entry, so it is checked first.
  always_comb begin
    logic [AW-1:0] idx;
    fwd1_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_valid = 1'b0;
    fwd2_data  = '0;
    idx        = '0;
    if (RegWrite && (rs1 != 5'd0) && (rd == rs1)) begin
      fwd1_valid = 1'b1;
      fwd1_data  = WriteData;
    end
    if (RegWrite && (rs2 != 5'd0) && (rd == rs2)) begin
      fwd2_valid = 1'b1;
      fwd2_data  = WriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if ((rs1 != 5'd0) && (mem_rd[idx] == rs1)) begin
          fwd1_valid = 1'b1;
          fwd1_data  = mem_data[idx];
        end
        if ((rs2 != 5'd0) && (mem_rd[idx] == rs2)) begin
          fwd2_valid = 1'b1;
          fwd2_data  = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back end of the register file interface: accepts (rd, data) results from the execute side and drives the register file write port (RegWrite, rd, WriteData).
- Pending results sit in an in-order DEPTH-entry FIFO; one is drained per cycle into a registered write stage.
- Forwards pending values to the rs1/rs2 read path so decode never sees stale register file data.

Parameters:
- XLEN, 64, data width of results and register file.
- DEPTH, 4, pending-result FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  result beat offered.
- in_ready  output  1  unit can accept a beat.
- in_rd  input  5  destination register of the beat.
- in_data  input  XLEN  result value.
- flush  input  1  synchronous discard of all pending writes.
- RegWrite  output  1  register file write enable.
- rd  output  5  register file write address.
- WriteData  output  XLEN  register file write data.
- rs1  input  5  decode read address 1.
- rs2  input  5  decode read address 2.
- fwd1_valid  output  1  rs1 has a pending newer value.
- fwd1_data  output  XLEN  forwarded value for rs1.
- fwd2_valid  output  1  rs2 has a pending newer value.
- fwd2_data  output  XLEN  forwarded value for rs2.
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, any time, including mid-drain): FIFO empty, pointers 0, count=0, RegWrite=0, rd=0, WriteData=0, fwd*_valid=0, fwd*_data=0. in_ready=1 once reset deasserts.
- in_ready = (count != DEPTH), combinational from count only. A full FIFO does not accept a beat in the same cycle it pops.
- Handshake: a beat transfers on a rising edge with in_valid && in_ready.
  - in_rd != 0: beat is written at the tail, and the tail pointer increments mod DEPTH.
  - in_rd == 0: beat is consumed (handshake completes) but not stored; count is unchanged.
- Drain: on every edge with count > 0 and no flush, the head is popped into the write stage.
  - RegWrite=1, rd and WriteData take the head fields for exactly one cycle.
  - The head pointer increments mod DEPTH.
  - On an edge with count == 0, RegWrite=0; rd and WriteData hold their previous values.
- Latency: a beat accepted at edge N into an empty FIFO drives RegWrite high during cycle N+1. The register file captures it at edge N+2.
- Back-to-back: with a continuous stream, one write per cycle and count stays constant. Push and pop on the same edge leave count unchanged.
- Ordering: writes reach the register file in acceptance order, including repeated writes to the same rd.
- Forwarding (combinational from rs1/rs2 and state):
  - Candidates are all valid FIFO entries plus the write stage when RegWrite=1.
  - The youngest candidate with matching rd wins. The youngest FIFO entry is nearest the tail; any FIFO entry is younger than the write stage.
  - fwdN_valid=1, fwdN_data = that candidate's data.
  - No match, or rsN == 0: fwdN_valid=0, fwdN_data=0.
  - The beat on in_* during the current cycle is never forwarded.
- flush: on an edge with flush=1, FIFO is emptied (count=0, head=tail) and RegWrite=0 next cycle.
  - A beat offered in the same cycle is consumed but discarded (flush wins over push).
  - A write already showing RegWrite=1 during the flush cycle still completes at that edge.
- count arithmetic: +1 on a stored push, -1 on a pop, unchanged on both or neither. It never exceeds DEPTH and never underflows.

Test Plan:
- Reset mid-stream: fill 3 entries, assert reset asynchronously between edges -> RegWrite, count, fwd*_valid drop to 0 immediately. After release in_ready=1 and no stale writes appear.
- Single write: beat rd=5, data=0xDEAD_BEEF accepted at edge N -> RegWrite=1, rd=5, WriteData=0xDEADBEEF in cycle N+1 only. count goes 1 then 0.
- Full/backpressure: hold in_valid with RegWrite-side drain, push 5 beats in consecutive cycles with rd=1..5, DEPTH=4 -> all 5 written in order rd=1..5, one per cycle. Then, with the same 4 beats pushed while count==4 and a pop pending, in_ready=0 for that cycle and the beat is held.
- Forwarding priority: push rd=7 data=0x11, then rd=7 data=0x22, set rs1=7, rs2=0 -> fwd1_valid=1, fwd1_data=0x22. fwd2_valid=0. After both drain, fwd1_valid=0.
- x0 discard: beat rd=0 data=0xFF accepted -> in_ready handshake completes, count stays 0, RegWrite never asserts.
- Flush with simultaneous push: 3 entries pending plus a beat rd=9 offered with flush=1 -> count=0 next cycle, no further RegWrite, and rd=9 is never written.
